// File: rtl/addr_ptr_pkg.sv
// Shared opcode encoding and helpers for the address pointer bank.
// Contents: OP_* opcodes (3 bits), ptr_op_t, ptr_max().
// Used by addr_ptr_cell and addr_ptr_bank via import addr_ptr_pkg::*.
package addr_ptr_pkg;

  typedef logic [2:0] ptr_op_t;

  localparam ptr_op_t OP_NOP  = 3'd0;
  localparam ptr_op_t OP_CLR  = 3'd1;
  localparam ptr_op_t OP_INC  = 3'd2;
  localparam ptr_op_t OP_DEC  = 3'd3;
  localparam ptr_op_t OP_LOAD = 3'd4;
  localparam ptr_op_t OP_FCLR = 3'd5;
  // Codes 6 and 7 are unassigned and decode as hold.

  // Largest value an aw-bit pointer can hold (2^aw - 1).
  function automatic logic [31:0] ptr_max(input int aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/addr_ptr_cell.sv
// One pointer channel: AW-bit register with sticky overflow/underflow flags.
// Latency: op applied on the rising edge, new value visible right after it.
// Backpressure: none; every enabled op is accepted in the cycle it is presented.
// Ports: clk, rst_n (async active-low), en (channel selected), op, ld_val,
//        ptr (registered pointer), ovf/udf (sticky flags).
// Config: ADDR_PTR_WRAP_EN selects modulo arithmetic; default saturates.
module addr_ptr_cell
  import addr_ptr_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  ptr_op_t       op,
  input  logic [AW-1:0] ld_val,
  output logic [AW-1:0] ptr,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW-1:0] PTR_MAX = AW'(ptr_max(AW));

  logic [AW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  always_comb begin
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (en) begin
      case (op)
        OP_CLR:  ptr_d = '0;
        OP_INC: begin
          if (ptr_q == PTR_MAX) begin
            ovf_d = 1'b1;
`ifdef ADDR_PTR_WRAP_EN
            ptr_d = '0;
`else
            ptr_d = PTR_MAX;
`endif
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        OP_DEC: begin
          if (ptr_q == '0) begin
            udf_d = 1'b1;
`ifdef ADDR_PTR_WRAP_EN
            ptr_d = PTR_MAX;
`else
            ptr_d = '0;
`endif
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end
        OP_LOAD: ptr_d = ld_val;
        OP_FCLR: begin
          ovf_d = 1'b0;
          udf_d = 1'b0;
        end
        default: ;  // NOP and unassigned codes hold
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ptr = ptr_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: rtl/addr_ptr_bank.sv
// Bank of NCH independent address pointers driven by a per-cycle opcode.
// Latency: 1 cycle op->register; addr_o/at_min/at_max follow ch combinationally.
// Backpressure: none; one op per cycle to the selected channel, always accepted.
// Ports: clk, rst_n (async active-low), op, ch, ld_val in; addr_o, addr_all,
//        at_min, at_max, ovf[NCH], udf[NCH] out.
// Config: ADDR_PTR_WRAP_EN selects modulo arithmetic; default saturates.
module addr_ptr_bank
  import addr_ptr_pkg::*;
#(
  parameter  int AW  = 5,
  parameter  int NCH = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ptr_op_t           op,
  input  logic [CHW-1:0]    ch,
  input  logic [AW-1:0]     ld_val,
  output logic [AW-1:0]     addr_o,
  output logic [NCH*AW-1:0] addr_all,
  output logic              at_min,
  output logic              at_max,
  output logic [NCH-1:0]    ovf,
  output logic [NCH-1:0]    udf
);

  logic [NCH-1:0]         en;
  logic [NCH-1:0][AW-1:0] ptr_w;

  // One-hot channel enable; a ch beyond NCH-1 matches nothing, so the op is dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_cell
    assign en[i] = (ch == CHW'(i));

    addr_ptr_cell #(
      .AW(AW)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[i]),
      .op     (op),
      .ld_val (ld_val),
      .ptr    (ptr_w[i]),
      .ovf    (ovf[i]),
      .udf    (udf[i])
    );
  end

  // Read mux; an out-of-range ch reads as zero.
  always_comb begin
    addr_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) addr_o = ptr_w[i];
    end
  end

  // Packed array flattens with channel i at bits [i*AW +: AW].
  assign addr_all = ptr_w;
  assign at_min   = (addr_o == '0);
  assign at_max   = (addr_o == '1);

endmodule

// File: doc/addr_ptr_bank.md
Name: addr_ptr_bank

Overview:
- Bank of NCH independent address pointers for the lab's RAM / stack / queue datapaths.
- Each pointer is AW bits wide and is driven by an opcode from the control FSM: clear, increment, decrement or load.
- Adds parallel load, min/max status and sticky overflow/underflow flags.
- Sits between the control-state decoder and the memory address mux.

Parameters:
- AW, 5, pointer width in bits.
- NCH, 4, number of pointer channels.
- CHW, $clog2(NCH) (min 1), channel-select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3  opcode, applied to the selected channel only.
- ch  in  CHW  channel select for op and for addr_o.
- ld_val  in  AW  load value for OP_LOAD.
- addr_o  out  AW  pointer of channel ch; combinational mux of the registers.
- addr_all  out  NCH*AW  all pointers, flat; channel i at bits [i*AW +: AW].
- at_min  out  1  addr_o == 0.
- at_max  out  1  addr_o == 2^AW-1.
- ovf  out  NCH  sticky per-channel overflow flag.
- udf  out  NCH  sticky per-channel underflow flag.

Behaviour:
- Opcodes:
  - 0 OP_NOP: hold.
  - 1 OP_CLR: pointer := 0. Flags unchanged.
  - 2 OP_INC: pointer := pointer + 1.
  - 3 OP_DEC: pointer := pointer - 1.
  - 4 OP_LOAD: pointer := ld_val.
  - 5 OP_FCLR: ovf[ch] := 0 and udf[ch] := 0; pointer holds.
  - 6, 7: treated as NOP.
- Timing:
  - op is sampled on the rising edge of clk.
  - The new pointer value is visible on addr_o / addr_all the same cycle after that edge (1-cycle latency from op to the registered value).
  - at_min and at_max follow addr_o combinationally; they track ch changes immediately.
- Unselected channels always hold.
- Only one channel is modified per cycle; no simultaneous multi-channel ops.
- Arithmetic is modulo or saturating per WRAP_EN (see Optional Feature).
- Boundary cases:
  - INC at 2^AW-1 sets ovf[ch] := 1.
  - DEC at 0 sets udf[ch] := 1.
  - Flags stay set until OP_FCLR or reset.
  - LOAD never sets flags.
  - FCLR and a boundary event cannot coincide, since there is one op per cycle.
- ch >= NCH (non-power-of-two NCH): op is ignored and addr_o = 0.
- Reset:
  - rst_n low immediately (asynchronously) forces every pointer, ovf and udf to 0.
  - This holds mid-operation as well; the op sampled during reset is lost.
  - Release is synchronous to clk by the instantiating design.

Optional Feature:
- Macro: ADDR_PTR_WRAP_EN.
- Defined: INC at max gives 0 and DEC at 0 gives 2^AW-1 (modulo arithmetic); ovf/udf are still set.
- Undefined (default): saturating. INC at max holds at max; DEC at 0 holds at 0; ovf/udf are set.

Decomposition:
- Package addr_ptr_pkg holds:
  - OP_NOP..OP_FCLR as 3-bit localparams;
  - typedef ptr_op_t;
  - function ptr_max(AW).
- Sub-module addr_ptr_cell is one channel: pointer register plus ovf/udf, with ports clk, rst_n, en, op, ld_val, ptr, ovf, udf.
- The bank generates NCH cells and decodes ch into the en one-hot, plus the addr_o mux and at_min/at_max.

Test Plan:
- Reset: rst_n=0 mid-run with pointers at 7/3/0/31 -> all addr_all=0, ovf=udf=0 without waiting for a clock edge.
- Count: ch=2; INC x5; DEC x2 -> addr_o=3; other channels stay 0; at_min=0.
- Load and top boundary: ch=1, LOAD 30; INC; INC:
  - wrap build -> addr_o=0, ovf=4'b0010;
  - saturate build -> addr_o=31, at_max=1, ovf=4'b0010.
- Bottom boundary: ch=3, CLR; DEC -> udf=4'b1000; addr_o=31 (wrap) or 0 with at_min=1 (saturate). Then FCLR -> udf=0, pointer unchanged.
- Illegal opcodes: ops 6 and 7 on ch=0 at value 9 -> value stays 9, no flags set.
- Channel switching: ch toggled 0/2 every cycle with op=NOP -> addr_o alternates between the stored values with zero latency, and no register changes.
